// File: rtl/ym3812_timer_model_pkg.sv
// Shared definitions for the YM3812 host-interface model:
// register indices, control/status bit positions and busy FSM states.
package ym3812_timer_model_pkg;

    localparam logic [7:0] REG_T1   = 8'h02;
    localparam logic [7:0] REG_T2   = 8'h03;
    localparam logic [7:0] REG_CTRL = 8'h04;

    localparam int CTL_RST = 7;
    localparam int CTL_M1  = 6;
    localparam int CTL_M2  = 5;
    localparam int CTL_ST2 = 1;
    localparam int CTL_ST1 = 0;

    localparam int ST_IRQ = 7;
    localparam int ST_T1F = 6;
    localparam int ST_T2F = 5;

    typedef enum logic [1:0] {
        BUSY_IDLE = 2'd0,
        BUSY_ADDR = 2'd1,
        BUSY_DATA = 2'd2
    } busy_st_t;

    typedef struct packed {
        logic       mask1;
        logic       mask2;
        logic       start2;
        logic       start1;
    } ctrl_t;

endpackage

// File: rtl/ym3812_timer.sv
// One OPL2 timer: 8-bit up-counter reloaded from a preset on overflow,
// with start/mask control and a sticky overflow flag.
module ym3812_timer (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       tick,
    input  logic       start,
    input  logic       mask,
    input  logic       clr_flag,
    input  logic [7:0] preset,
    output logic       flag
);

    logic [7:0] cnt;
    logic       start_q;
    logic       ovf;

    assign ovf = start && start_q && tick && (cnt == 8'hFF);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt     <= 8'h00;
            start_q <= 1'b0;
        end else begin
            start_q <= start;
            if (start && !start_q) begin
                cnt <= preset;
            end else if (start && tick) begin
                cnt <= (cnt == 8'hFF) ? preset : cnt + 8'd1;
            end
        end
    end

    // A new overflow takes priority over a clear in the same cycle
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            flag <= 1'b0;
        end else if (ovf && !mask) begin
            flag <= 1'b1;
        end else if (clr_flag) begin
            flag <= 1'b0;
        end
    end

endmodule

// File: rtl/ym3812_timer_model.sv
// YM3812 (OPL2) host-bus model: write capture, status, Timer 1/2, IRQ.
// Define YM_BUSY_MODEL_EN to model the post-write busy window and overrun.
module ym3812_timer_model
    import ym3812_timer_model_pkg::*;
#(
    parameter int         TICK1_DIV  = 1145,
    parameter int         ADDR_BUSY  = 48,
    parameter int         DATA_BUSY  = 329,
    parameter logic [4:0] STATUS_LOW = 5'h06
) (
    input  logic       clk,
    input  logic       rst_l,
    inout  wire  [7:0] yd,
    input  logic       ym_cs_l,
    input  logic       ym_a0,
    input  logic       ym_wr_l,
    input  logic       ym_rd_l,
    output logic       ym_irq_l,
    output logic       reg_wr_stb,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       busy,
    output logic       wr_overrun
);

    localparam int PW = (TICK1_DIV > 1) ? $clog2(TICK1_DIV) : 1;

    logic [1:0] cs_sync;
    logic [1:0] wr_sync;
    logic [1:0] a0_sync;
    logic [7:0] yd_s1;
    logic [7:0] yd_s2;
    logic       strb_q;
    logic       a0_q;
    logic [7:0] yd_q;
    logic       strb;
    logic       commit;
    logic       accept;

    // Strobe and bus are brought into clk domain; a0/yd lag one stage
    // so the commit uses values captured while the strobe was still low.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cs_sync <= 2'b11;
            wr_sync <= 2'b11;
            a0_sync <= 2'b00;
            yd_s1   <= 8'h00;
            yd_s2   <= 8'h00;
            strb_q  <= 1'b1;
            a0_q    <= 1'b0;
            yd_q    <= 8'h00;
        end else begin
            cs_sync <= {cs_sync[0], ym_cs_l};
            wr_sync <= {wr_sync[0], ym_wr_l};
            a0_sync <= {a0_sync[0], ym_a0};
            yd_s1   <= yd;
            yd_s2   <= yd_s1;
            strb_q  <= strb;
            a0_q    <= a0_sync[1];
            yd_q    <= yd_s2;
        end
    end

    assign strb   = wr_sync[1] | cs_sync[1];
    assign commit = strb && !strb_q;

`ifdef YM_BUSY_MODEL_EN
    localparam int BMAX = (DATA_BUSY > ADDR_BUSY) ? DATA_BUSY : ADDR_BUSY;
    localparam int BCW  = $clog2(BMAX + 1);

    busy_st_t       bstate;
    logic [BCW-1:0] bcnt;

    assign accept = commit && (bstate == BUSY_IDLE);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            bstate     <= BUSY_IDLE;
            bcnt       <= '0;
            busy       <= 1'b0;
            wr_overrun <= 1'b0;
        end else begin
            unique case (bstate)
                BUSY_IDLE: begin
                    if (commit) begin
                        bstate <= a0_q ? BUSY_DATA : BUSY_ADDR;
                        bcnt   <= a0_q ? BCW'(DATA_BUSY - 1)
                                       : BCW'(ADDR_BUSY - 1);
                        busy   <= 1'b1;
                    end
                end
                BUSY_ADDR, BUSY_DATA: begin
                    if (commit) begin
                        wr_overrun <= 1'b1;
                    end
                    if (bcnt == '0) begin
                        bstate <= BUSY_IDLE;
                        busy   <= 1'b0;
                    end else begin
                        bcnt <= bcnt - BCW'(1);
                    end
                end
                default: begin
                    bstate <= BUSY_IDLE;
                    busy   <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_busy_cfg;

    assign unused_busy_cfg = (ADDR_BUSY != DATA_BUSY);
    assign accept          = commit;
    assign busy            = 1'b0;
    assign wr_overrun      = 1'b0;
`endif

    logic [7:0] index;
    logic [7:0] t1_preset;
    logic [7:0] t2_preset;
    ctrl_t      ctrl;
    logic       data_wr;
    logic       ctrl_hit;
    logic       clr_flags;
    logic       ctrl_wr;
    logic       pre_clr;

    assign data_wr   = accept && a0_q;
    assign ctrl_hit  = data_wr && (index == REG_CTRL);
    assign clr_flags = ctrl_hit && yd_q[CTL_RST];
    assign ctrl_wr   = ctrl_hit && !yd_q[CTL_RST];
    assign pre_clr   = ctrl_wr &&
                       ((yd_q[CTL_ST1] && !ctrl.start1) ||
                        (yd_q[CTL_ST2] && !ctrl.start2));

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            index       <= 8'h00;
            t1_preset   <= 8'h00;
            t2_preset   <= 8'h00;
            ctrl        <= '0;
            reg_wr_stb  <= 1'b0;
            reg_wr_addr <= 8'h00;
            reg_wr_data <= 8'h00;
        end else begin
            reg_wr_stb <= 1'b0;
            if (accept && !a0_q) begin
                index <= yd_q;
            end
            if (data_wr) begin
                reg_wr_stb  <= 1'b1;
                reg_wr_addr <= index;
                reg_wr_data <= yd_q;
                unique case (1'b1)
                    index == REG_T1: t1_preset <= yd_q;
                    index == REG_T2: t2_preset <= yd_q;
                    ctrl_wr: begin
                        ctrl.mask1  <= yd_q[CTL_M1];
                        ctrl.mask2  <= yd_q[CTL_M2];
                        ctrl.start2 <= yd_q[CTL_ST2];
                        ctrl.start1 <= yd_q[CTL_ST1];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Shared prescaler; restarted whenever either timer is started
    logic [PW-1:0] pre;
    logic [1:0]    quad;
    logic          tick1;
    logic          tick2;

    assign tick1 = (pre == PW'(TICK1_DIV - 1));
    assign tick2 = tick1 && (quad == 2'd3);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            pre  <= '0;
            quad <= 2'd0;
        end else if (pre_clr) begin
            pre  <= '0;
            quad <= 2'd0;
        end else if (tick1) begin
            pre  <= '0;
            quad <= quad + 2'd1;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    logic t1f;
    logic t2f;

    ym3812_timer u_t1 (
        .clk      (clk),
        .rst_l    (rst_l),
        .tick     (tick1),
        .start    (ctrl.start1),
        .mask     (ctrl.mask1),
        .clr_flag (clr_flags),
        .preset   (t1_preset),
        .flag     (t1f)
    );

    ym3812_timer u_t2 (
        .clk      (clk),
        .rst_l    (rst_l),
        .tick     (tick2),
        .start    (ctrl.start2),
        .mask     (ctrl.mask2),
        .clr_flag (clr_flags),
        .preset   (t2_preset),
        .flag     (t2f)
    );

    logic       irq;
    logic [7:0] status;
    logic       rd_en;

    assign irq                = t1f | t2f;
    assign status[ST_IRQ]     = irq;
    assign status[ST_T1F]     = t1f;
    assign status[ST_T2F]     = t2f;
    assign status[4:0]        = STATUS_LOW;
    assign ym_irq_l           = ~irq;
    assign rd_en              = !ym_rd_l && !ym_cs_l;
    assign yd = rd_en ? (ym_a0 ? 8'hFF : status) : 8'bz;

endmodule

// File: tb/tb_ym3812_timer_model.sv
// Directed bench for ym3812_timer_model: status reads, timers, IRQ,
// flag clear priority, busy/overrun and reset during a write.
module tb_ym3812_timer_model;

    logic       clk = 1'b0;
    logic       rst_l;
    wire  [7:0] yd;
    logic [7:0] yd_drv;
    logic       yd_oe;
    logic       ym_cs_l;
    logic       ym_a0;
    logic       ym_wr_l;
    logic       ym_rd_l;
    logic       ym_irq_l;
    logic       reg_wr_stb;
    logic [7:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       busy;
    logic       wr_overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int stb_cnt = 0;

    assign yd = yd_oe ? yd_drv : 8'bz;

    always #5 clk = ~clk;

    ym3812_timer_model dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .yd          (yd),
        .ym_cs_l     (ym_cs_l),
        .ym_a0       (ym_a0),
        .ym_wr_l     (ym_wr_l),
        .ym_rd_l     (ym_rd_l),
        .ym_irq_l    (ym_irq_l),
        .reg_wr_stb  (reg_wr_stb),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .busy        (busy),
        .wr_overrun  (wr_overrun)
    );

    always @(negedge clk) begin
        if (reg_wr_stb) stb_cnt = stb_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Commit lands on the 5th posedge after the first negedge
    task automatic ym_strobe(input logic a0, input logic [7:0] d);
        @(negedge clk);
        ym_cs_l = 1'b0;
        ym_a0   = a0;
        yd_drv  = d;
        yd_oe   = 1'b1;
        ym_wr_l = 1'b0;
        repeat (2) @(negedge clk);
        ym_wr_l = 1'b1;
        @(negedge clk);
        ym_cs_l = 1'b1;
        yd_oe   = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic ym_write(input logic a0, input logic [7:0] d);
        ym_strobe(a0, d);
        repeat (340) @(negedge clk);
    endtask

    task automatic ym_read(input logic a0, output logic [7:0] v);
        @(negedge clk);
        ym_a0   = a0;
        ym_cs_l = 1'b0;
        ym_rd_l = 1'b0;
        #1 v = yd;
        ym_rd_l = 1'b1;
        ym_cs_l = 1'b1;
    endtask

    logic [7:0] rd;
    int         base;
    logic       exp_busy;
    logic [7:0] exp_idx;

    initial begin
`ifdef YM_BUSY_MODEL_EN
        exp_busy = 1'b1;
        exp_idx  = 8'h20;
`else
        exp_busy = 1'b0;
        exp_idx  = 8'h30;
`endif
        rst_l   = 1'b0;
        ym_cs_l = 1'b1;
        ym_a0   = 1'b0;
        ym_wr_l = 1'b1;
        ym_rd_l = 1'b1;
        yd_drv  = 8'h00;
        yd_oe   = 1'b0;
        repeat (5) @(negedge clk);
        rst_l = 1'b1;
        repeat (5) @(negedge clk);

        check("rst_irq_l", ym_irq_l, 1'b1);
        check("rst_stb", reg_wr_stb, 1'b0);
        check("rst_addr", reg_wr_addr, 8'h00);
        check("rst_data", reg_wr_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_ovr", wr_overrun, 1'b0);
        ym_read(1'b0, rd);
        check("rst_status", rd, 8'h06);
        ym_read(1'b1, rd);
        check("rst_a0_1", rd, 8'hFF);

        ym_write(1'b0, 8'h02);
        ym_write(1'b1, 8'hFF);
        check("t1p_stb", stb_cnt, 1);
        check("t1p_addr", reg_wr_addr, 8'h02);
        check("t1p_data", reg_wr_data, 8'hFF);

        ym_write(1'b0, 8'h04);
        ym_write(1'b1, 8'h01);
        repeat (700) @(negedge clk);
        ym_read(1'b0, rd);
        check("t1_early", rd, 8'h06);
        check("t1_early_irq", ym_irq_l, 1'b1);
        repeat (200) @(negedge clk);
        ym_read(1'b0, rd);
        check("t1_ovf", rd, 8'hC6);
        check("t1_ovf_irq", ym_irq_l, 1'b0);

        ym_strobe(1'b1, 8'h80);
        ym_read(1'b0, rd);
        check("clr_status", rd, 8'h06);
        check("clr_irq", ym_irq_l, 1'b1);
        repeat (1100) @(negedge clk);
        ym_read(1'b0, rd);
        check("t1_reovf", rd, 8'hC6);

        ym_write(1'b1, 8'h00);
        ym_write(1'b1, 8'h80);
        ym_read(1'b0, rd);
        check("stop_clr", rd, 8'h06);
        ym_write(1'b0, 8'h03);
        ym_write(1'b1, 8'hFE);
        ym_write(1'b0, 8'h04);
        ym_write(1'b1, 8'h22);
        repeat (9300) @(negedge clk);
        ym_read(1'b0, rd);
        check("t2_masked", rd, 8'h06);
        ym_write(1'b1, 8'h42);
        repeat (9000) @(negedge clk);
        ym_read(1'b0, rd);
        check("t2_unmasked", rd, 8'hA6);
        check("t2_irq", ym_irq_l, 1'b0);
        ym_write(1'b1, 8'h62);
        ym_read(1'b0, rd);
        check("mask_keeps", rd, 8'hA6);

        ym_write(1'b0, 8'h20);
        base = stb_cnt;
        ym_strobe(1'b1, 8'h5A);
        check("busy_win", busy, exp_busy);
        repeat (4) @(negedge clk);
        ym_strobe(1'b0, 8'h30);
        repeat (400) @(negedge clk);
        check("busy_stb", stb_cnt - base, 1);
        check("busy_addr", reg_wr_addr, 8'h20);
        check("busy_data", reg_wr_data, 8'h5A);
        check("overrun", wr_overrun, exp_busy);
        check("busy_end", busy, 1'b0);
        ym_write(1'b1, 8'h77);
        check("idx_after", reg_wr_addr, exp_idx);
        check("data_after", reg_wr_data, 8'h77);

        ym_write(1'b0, 8'h04);
        ym_write(1'b1, 8'h00);
        ym_write(1'b1, 8'h80);
        ym_read(1'b0, rd);
        check("pre_coin", rd, 8'h06);
        ym_write(1'b1, 8'h01);
        repeat (798) @(negedge clk);
        ym_strobe(1'b1, 8'h80);
        ym_read(1'b0, rd);
        check("set_wins", rd, 8'hC6);

        base = stb_cnt;
        @(negedge clk);
        ym_cs_l = 1'b0;
        ym_a0   = 1'b1;
        yd_drv  = 8'h33;
        yd_oe   = 1'b1;
        ym_wr_l = 1'b0;
        repeat (2) @(negedge clk);
        rst_l = 1'b0;
        repeat (2) @(negedge clk);
        ym_wr_l = 1'b1;
        ym_cs_l = 1'b1;
        yd_oe   = 1'b0;
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_stb", stb_cnt - base, 0);
        check("mid_irq_l", ym_irq_l, 1'b1);
        check("mid_addr", reg_wr_addr, 8'h00);
        check("mid_data", reg_wr_data, 8'h00);
        check("mid_busy", busy, 1'b0);
        check("mid_ovr", wr_overrun, 1'b0);
        ym_read(1'b0, rd);
        check("mid_status", rd, 8'h06);
        repeat (1300) @(negedge clk);
        ym_read(1'b0, rd);
        check("mid_timer_off", rd, 8'h06);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
